palette_lookup_arbiter: RTL and testbench



---
 rtl/palette_lookup_arbiter_pkg.sv | 20 ++
 rtl/palette_lookup_arbiter_if.sv | 40 ++++
 rtl/palette_lookup_arbiter_rr_arbiter.sv | 47 ++++
 rtl/palette_lookup_arbiter.sv | 127 ++++++++++++
 tb/tb_palette_lookup_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/palette_lookup_arbiter_pkg.sv
// Shared types and constants for the sprite palette lookup path.
package palette_pkg;

  localparam int COLOR_W         = 24;
  localparam int IDX_W           = 4;
  localparam int TRANSPARENT_IDX = 0;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [IDX_W-1:0]   pal_idx_t;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_t;

  function automatic logic is_transparent(input pal_idx_t idx);
    return idx == pal_idx_t'(TRANSPARENT_IDX);
  endfunction

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Request, response and loader-write bundle between sprite renderers, loader and the palette arbiter.
interface palette_lookup_arbiter_if
  import palette_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BANK = 8
);
  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int ID_W   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*BANK_W-1:0] i_req_bank;
  logic [NUM_REQ*IDX_W-1:0]  i_req_idx;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_rsp_valid;
  logic [ID_W-1:0]           o_rsp_id;
  color_t                    o_rsp_color;
  logic                      o_rsp_transparent;
  logic                      i_rsp_ready;
  logic                      i_wr_en;
  logic [BANK_W-1:0]         i_wr_bank;
  pal_idx_t                  i_wr_idx;
  color_t                    i_wr_color;
  logic                      o_busy;

  modport master (
    output i_req_valid, i_req_bank, i_req_idx, i_rsp_ready,
           i_wr_en, i_wr_bank, i_wr_idx, i_wr_color,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_color,
           o_rsp_transparent, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_bank, i_req_idx, i_rsp_ready,
           i_wr_en, i_wr_bank, i_wr_idx, i_wr_color,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_color,
           o_rsp_transparent, o_busy
  );

endinterface

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a registered pointer.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_grant_vld
);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;
  logic [ID_W-1:0] w_idx;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    // Index arithmetic is ID_W bits wide, so the search wraps naturally.
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!w_found && i_valid[r_ptr + ID_W'(off)]) begin
        w_found = 1'b1;
        w_idx   = r_ptr + ID_W'(off);
      end
    end
  end

  assign o_grant_vld = i_enable && w_found;
  assign o_grant_id  = w_idx;
  assign o_grant     = o_grant_vld ? (NUM_REQ'(1) << w_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (o_grant_vld) begin
      r_ptr <= w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shared sprite palette RAM with round-robin lookup arbitration, loader write port and power-up clear.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BANK = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  palette_lookup_arbiter_if.slave bus
);

  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = 1 << ADDR_W;

  arb_state_t          r_state, w_state_nxt;
  logic [ADDR_W:0]     r_clr_cnt, w_clr_cnt_nxt;
  logic                w_busy;

  color_t              r_mem [DEPTH];
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  color_t              w_mem_wdata;

  logic                w_slot_free;
  logic                w_grant_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_id;
  logic                w_grant_vld;
  logic [BANK_W-1:0]   w_sel_bank;
  pal_idx_t            w_sel_idx;
  logic [ADDR_W-1:0]   w_rd_addr;

  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  color_t              r_rsp_color;
  logic                r_rsp_transparent;

  assign w_slot_free = !r_rsp_valid || bus.i_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_busy        = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = {bus.i_wr_bank, bus.i_wr_idx};
    w_mem_wdata   = bus.i_wr_color;
    w_grant_en    = 1'b0;
    unique case (r_state)
      INIT: begin
        // Loader writes are dropped while the clear sweeps every entry.
        w_busy        = 1'b1;
        w_mem_we      = 1'b1;
        w_mem_addr    = r_clr_cnt[ADDR_W-1:0];
        w_mem_wdata   = '0;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (w_clr_cnt_nxt[ADDR_W]) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_mem_we   = bus.i_wr_en;
        w_grant_en = !bus.i_wr_en && w_slot_free;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (bus.i_req_valid),
    .i_enable    (w_grant_en),
    .o_grant     (w_grant),
    .o_grant_id  (w_grant_id),
    .o_grant_vld (w_grant_vld)
  );

  assign w_sel_bank = bus.i_req_bank[w_grant_id*BANK_W +: BANK_W];
  assign w_sel_idx  = bus.i_req_idx[w_grant_id*IDX_W +: IDX_W];
  assign w_rd_addr  = {w_sel_bank, w_sel_idx};

  // NOTE: the palette array has no reset; the INIT sweep clears it, which
  // keeps it mappable onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // A write suppresses the grant, so the read never collides with a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid       <= 1'b0;
      r_rsp_id          <= '0;
      r_rsp_color       <= '0;
      r_rsp_transparent <= 1'b0;
    end else if (w_grant_vld) begin
      r_rsp_valid       <= 1'b1;
      r_rsp_id          <= w_grant_id;
      r_rsp_transparent <= is_transparent(w_sel_idx);
      r_rsp_color       <= is_transparent(w_sel_idx) ? '0 : r_mem[w_rd_addr];
    end else if (w_slot_free) begin
      r_rsp_valid       <= 1'b0;
    end
  end

  assign bus.o_req_ready       = w_grant;
  assign bus.o_rsp_valid       = r_rsp_valid;
  assign bus.o_rsp_id          = r_rsp_id;
  assign bus.o_rsp_color       = r_rsp_color;
  assign bus.o_rsp_transparent = r_rsp_transparent;
  assign bus.o_busy            = w_busy;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Randomized bench for palette_lookup_arbiter against an array-based palette and arbitration model.
module tb_palette_lookup_arbiter;

  localparam int NR = 4;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  palette_lookup_arbiter_if #(.NUM_REQ(NR), .NUM_BANK(NB)) bus ();

  palette_lookup_arbiter #(.NUM_REQ(NR), .NUM_BANK(NB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_known = 1'b0;
  int          m_init_left;
  int          m_ptr;
  int          m_last_grant;
  bit          m_rsp_valid;
  int          m_rsp_id;
  logic [23:0] m_rsp_color;
  bit          m_rsp_tr;
  logic [23:0] m_mem [NB][16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare at negedge against the model, advance the model, return just after posedge.
  task automatic cycle();
    int win;
    bit slot;
    int b, ix;
    win  = -1;
    slot = 1'b0;
    @(negedge clk);
    if (!rst && m_known) begin
      check("busy", bus.o_busy, m_init_left > 0);
      slot = !m_rsp_valid || bus.i_rsp_ready;
      if (m_init_left == 0 && !bus.i_wr_en && slot) begin
        for (int o = 0; o < NR; o++) begin
          if (win < 0 && bus.i_req_valid[(m_ptr + o) % NR]) win = (m_ptr + o) % NR;
        end
      end
      check("ready", bus.o_req_ready, (win >= 0) ? 4'(1 << win) : 4'b0);
      check("rsp_valid", bus.o_rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
        check("rsp_id", bus.o_rsp_id, m_rsp_id);
        check("rsp_color", bus.o_rsp_color, m_rsp_color);
        check("rsp_transparent", bus.o_rsp_transparent, m_rsp_tr);
      end
    end
    if (rst) begin
      m_known      = 1'b1;
      m_init_left  = NB * 16;
      m_ptr        = 0;
      m_last_grant = -1;
      m_rsp_valid  = 1'b0;
      for (int i = 0; i < NB; i++)
        for (int j = 0; j < 16; j++) m_mem[i][j] = '0;
    end else if (m_known) begin
      if (m_init_left > 0) begin
        m_init_left--;
      end else begin
        m_last_grant = win;
        if (win >= 0) begin
          b  = int'(bus.i_req_bank[win*3 +: 3]);
          ix = int'(bus.i_req_idx[win*4 +: 4]);
          m_rsp_valid = 1'b1;
          m_rsp_id    = win;
          m_rsp_tr    = (ix == 0);
          m_rsp_color = (ix == 0) ? 24'h0 : m_mem[b][ix];
          m_ptr       = (win + 1) % NR;
        end else if (slot) begin
          m_rsp_valid = 1'b0;
        end
        if (bus.i_wr_en) m_mem[int'(bus.i_wr_bank)][int'(bus.i_wr_idx)] = bus.i_wr_color;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input int bank, input int idx);
    bus.i_req_valid[k]        = v;
    bus.i_req_bank[k*3 +: 3]  = 3'(bank);
    bus.i_req_idx[k*4 +: 4]   = 4'(idx);
  endtask

  task automatic write(input int bank, input int idx, input logic [23:0] color);
    bus.i_wr_en    = 1'b1;
    bus.i_wr_bank  = 3'(bank);
    bus.i_wr_idx   = 4'(idx);
    bus.i_wr_color = color;
  endtask

  task automatic count_busy(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.o_busy) break;
      nb++;
      cycle();
    end
    check(tag, nb, NB * 16);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_bank  = '0;
    bus.i_req_idx   = '0;
    bus.i_rsp_ready = 1'b1;
    bus.i_wr_en     = 1'b0;
    bus.i_wr_bank   = '0;
    bus.i_wr_idx    = '0;
    bus.i_wr_color  = '0;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset values and the full clear sweep; a write during INIT must be dropped.
    check("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
    check("rst_rsp_id", bus.o_rsp_id, 0);
    check("rst_rsp_color", bus.o_rsp_color, 0);
    check("rst_rsp_transparent", bus.o_rsp_transparent, 1'b0);
    check("rst_ready", bus.o_req_ready, 4'b0);
    write(3, 5, 24'habcdef);
    count_busy("busy_cycles");
    bus.i_wr_en = 1'b0;

    // Cleared entry reads back as opaque black.
    set_req(0, 1'b1, 3, 5);
    cycle();
    set_req(0, 1'b0, 0, 0);
    cycle();

    // Write then read on the next cycle; index 0 is forced transparent.
    write(1, 2, 24'h7fffff);
    cycle();
    bus.i_wr_en = 1'b0;
    set_req(0, 1'b1, 1, 2);
    cycle();
    set_req(0, 1'b0, 0, 0);
    cycle();
    write(1, 0, 24'h00ffff);
    cycle();
    bus.i_wr_en = 1'b0;
    set_req(0, 1'b1, 1, 0);
    cycle();
    set_req(0, 1'b0, 0, 0);
    cycle();

    // All requesters valid: rotation with one response per cycle.
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, $urandom_range(0, NB-1), $urandom_range(0, 15));
    for (int i = 0; i < 12; i++) cycle();

    // Backpressure on a response from requester 2.
    for (int i = 0; i < 8; i++) begin
      if (m_last_grant == 2) break;
      cycle();
    end
    check("found_grant2", m_last_grant, 2);
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    bus.i_rsp_ready = 1'b1;
    cycle();
    check("grant_after_release", m_last_grant, 3);
    bus.i_req_valid = '0;
    cycle();

    // Three back-to-back writes block requester 1, which then sees the last value.
    set_req(1, 1'b1, 5, 7);
    write(5, 7, 24'h111111);
    cycle();
    write(5, 7, 24'h222222);
    cycle();
    write(5, 7, 24'h333333);
    cycle();
    bus.i_wr_en = 1'b0;
    cycle();
    set_req(1, 1'b0, 0, 0);
    cycle();

    // Reset mid-stream with a response in flight.
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1, 2);
    cycle();
    cycle();
    check("pre_rst_rsp_valid", bus.o_rsp_valid, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.i_req_valid = '0;
    check("post_rst_rsp_valid", bus.o_rsp_valid, 1'b0);
    check("post_rst_busy", bus.o_busy, 1'b1);
    count_busy("busy_cycles_again");
    set_req(2, 1'b1, 1, 2);
    cycle();
    set_req(2, 1'b1, 5, 7);
    cycle();
    bus.i_req_valid = '0;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NR; k++)
        set_req(k, ($urandom_range(0, 2) != 0), $urandom_range(0, NB-1),
                ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15));
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0)
        write($urandom_range(0, NB-1), $urandom_range(0, 15), 24'($urandom));
      else
        bus.i_wr_en = 1'b0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
